// File: rtl/sprint1_dl_pkg.sv
// Shared types and defaults for the ROM download streamer.
package sprint1_dl_pkg;

  localparam int DL_ADDR_W        = 17;
  localparam int GAP_CYCLES_DEF   = 3;
  localparam int HOLD_CYCLES_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_HOLD
  } dl_state_e;

endpackage

// File: rtl/rom_download_streamer.sv
// Streams source bytes into a core's ioctl-style download port, paced by a gap
// between strobes, then holds the core in reset before reporting completion.
module rom_download_streamer
  import sprint1_dl_pkg::*;
#(
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DL_ADDR_W-1:0] total_len,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DL_ADDR_W-1:0] dn_addr,
  output logic [7:0]           dn_data,
  output logic                 dn_wr,
  output logic                 dn_download,
  output logic                 core_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int CNT_MAX   = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  dl_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DL_ADDR_W-1:0]   idx_q, idx_d;
  logic [DL_ADDR_W-1:0]   len_q, len_d;
  logic [DL_ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic [DL_ADDR_W-1:0]   idx_inc;

  assign idx_inc = idx_q + 17'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    addr_d    = addr_q;
    data_d    = data_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start outranks abort here; abort alone is a no-op in IDLE
        if (start) begin
          aborted_d = 1'b0;
          len_d     = total_len;
          idx_d     = '0;
          if (total_len == '0) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(HOLD_LOAD);
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d   = ST_HOLD;
          cnt_d     = CNT_W'(HOLD_LOAD);
          aborted_d = 1'b1;
        end else if (s_valid) begin
          addr_d  = idx_q;
          data_d  = s_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_inc;
        if (abort) begin
          state_d   = ST_HOLD;
          cnt_d     = CNT_W'(HOLD_LOAD);
          aborted_d = 1'b1;
        end else if (idx_inc == len_q) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_LOAD);
        end else if (GAP_CYCLES == 0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_LOAD);
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d   = ST_HOLD;
          cnt_d     = CNT_W'(HOLD_LOAD);
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign s_ready      = (state_q == ST_FETCH) && !abort;
  assign dn_wr        = (state_q == ST_WRITE);
  assign dn_download  = (state_q == ST_FETCH) || (state_q == ST_WRITE) || (state_q == ST_GAP);
  assign busy         = (state_q != ST_IDLE);
  // Core stays in reset for the whole download, the hold window, and our own reset
  assign core_reset_n = !(reset || dn_download || (state_q == ST_HOLD));
  assign dn_addr      = addr_q;
  assign dn_data      = data_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule
